// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and transmitter-side signals of the UART transmit scheduler.
interface uart_tx_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic                   tx_En;
    logic [NUM_REQ-1:0]     req;
    logic [8*NUM_REQ-1:0]   req_Data;
    logic [NUM_REQ-1:0]     req_Ack;
    logic [7:0]             tx_Data;
    logic                   tx_Start;
    logic [ID_W-1:0]        grant_Id;
    logic                   busy;

    modport master (
        output tx_En, req, req_Data,
        input  req_Ack, tx_Data, tx_Start, grant_Id, busy
    );

    modport slave (
        input  tx_En, req, req_Data,
        output req_Ack, tx_Data, tx_Start, grant_Id, busy
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters;
// frame timing is tracked locally because the transmitter has no busy output.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned FRAME_CYCLES = 11,
    parameter int unsigned GAP_CYCLES   = 0,
    parameter int unsigned ID_W         = 2
) (
    input  logic               sample_Clk,
    input  logic               reset,
    uart_tx_scheduler_if.slave bus
);
    // ISSUE and the IDLE grant cycle make up the rest of the start-to-start spacing
    localparam int unsigned WAIT_LOAD = FRAME_CYCLES + GAP_CYCLES - 2;
    localparam int unsigned CNT_W     = $clog2(WAIT_LOAD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, busy_q;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot, scan;
    logic                 win_found, grant_c;
    logic [31:0]          win_off, win_sum, win_nxt;
    logic [ID_W-1:0]      win_idx, ptr_next;

    // Round-robin search: rotate req so the pointer lands on bit 0, take first set bit
    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        scan      = '0;
        req_dbl   = {bus.req, bus.req};
        req_rot   = NUM_REQ'(req_dbl >> ptr_q);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan = req_rot >> i;
            if (!win_found && scan[0]) begin
                win_found = 1'b1;
                win_off   = i;
            end
        end
        win_sum = 32'(ptr_q) + win_off;
        if (win_sum >= NUM_REQ) begin
            win_sum = win_sum - NUM_REQ;
        end
        win_nxt = win_sum + 32'd1;
        if (win_nxt >= NUM_REQ) begin
            win_nxt = 32'd0;
        end
        win_idx  = ID_W'(win_sum);
        ptr_next = ID_W'(win_nxt);
    end

    // The ack is the grant decision itself: seen at the capturing edge, never beside tx_Start
    assign grant_c     = reset && (state_q == IDLE) && bus.tx_En && win_found;
    assign bus.req_Ack = grant_c ? (NUM_REQ'(1) << win_idx) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        unique case (state_q)
            IDLE: begin
                if (grant_c) begin
                    tx_data_d  = 8'(bus.req_Data >> {win_idx, 3'b000});
                    grant_id_d = win_idx;
                    ptr_d      = ptr_next;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(WAIT_LOAD);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sample_Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            tx_start_q <= (state_d == ISSUE);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign bus.tx_Data  = tx_data_q;
    assign bus.tx_Start = tx_start_q;
    assign bus.grant_Id = grant_id_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: default instance plus one with a 4-cycle idle gap.
module tb_uart_tx_scheduler;
    logic sample_Clk;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;

    logic [7:0] rr_data [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    int         rr_id   [5] = '{0, 1, 2, 3, 0};

    uart_tx_scheduler_if #(.NUM_REQ(4), .ID_W(2)) ifa ();
    uart_tx_scheduler_if #(.NUM_REQ(4), .ID_W(2)) ifb ();

    uart_tx_scheduler #(.NUM_REQ(4), .FRAME_CYCLES(11), .GAP_CYCLES(0), .ID_W(2)) u_dut (
        .sample_Clk(sample_Clk),
        .reset     (reset),
        .bus       (ifa)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .FRAME_CYCLES(11), .GAP_CYCLES(4), .ID_W(2)) u_gap (
        .sample_Clk(sample_Clk),
        .reset     (reset),
        .bus       (ifb)
    );

    initial begin
        sample_Clk = 1'b0;
        forever #5 sample_Clk = ~sample_Clk;
    end

    // Ack must be one-hot and never share a cycle with tx_Start
    always @(negedge sample_Clk) begin
        if (reset) begin
            if ((ifa.req_Ack != 4'd0) && ifa.tx_Start) viol++;
            if ((ifb.req_Ack != 4'd0) && ifb.tx_Start) viol++;
            if ($countones(ifa.req_Ack) > 1) viol++;
            if ($countones(ifb.req_Ack) > 1) viol++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sample_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps until tx_Start, returning cycles taken and the last ack seen on the way
    task automatic wait_start(input bit b, output int gap, output logic [3:0] ack);
        gap = 0;
        ack = 4'd0;
        do begin
            #1;
            if ((b ? ifb.req_Ack : ifa.req_Ack) != 4'd0) ack = b ? ifb.req_Ack : ifa.req_Ack;
            @(posedge sample_Clk);
            #1;
            gap++;
        end while (!(b ? ifb.tx_Start : ifa.tx_Start) && gap < 40);
    endtask

    task automatic wait_idle(input bit b);
        int n;
        n = 0;
        while ((b ? ifb.busy : ifa.busy) && n < 40) begin
            step(1);
            n++;
        end
        chk("idle_reached", 32'(b ? ifb.busy : ifa.busy), 32'd0);
    endtask

    initial begin
        int         gap;
        int         cnt;
        int         starts;
        int         acks;
        logic [3:0] ack;

        reset        = 1'b0;
        ifa.tx_En    = 1'b0;
        ifa.req      = 4'd0;
        ifa.req_Data = 32'd0;
        ifb.tx_En    = 1'b0;
        ifb.req      = 4'd0;
        ifb.req_Data = 32'd0;

        // Reset, then a long quiet stretch
        step(3);
        chk("rst_tx_start", 32'(ifa.tx_Start), 32'd0);
        chk("rst_busy",     32'(ifa.busy),     32'd0);
        chk("rst_grant_id", 32'(ifa.grant_Id), 32'd0);
        chk("rst_tx_data",  32'(ifa.tx_Data),  32'd0);
        chk("rst_ack",      32'(ifa.req_Ack),  32'd0);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (ifa.tx_Start || ifa.busy || (ifa.req_Ack != 4'd0)) cnt++;
        end
        chk("idle_quiet", 32'(cnt), 32'd0);

        // All requesters active; tx_En and req rise together
        ifa.tx_En    = 1'b1;
        ifa.req      = 4'b1111;
        ifa.req_Data = 32'h4332_2110;
        for (int k = 0; k < 5; k++) begin
            wait_start(1'b0, gap, ack);
            chk("rr_ack",  32'(ack),          32'(1 << rr_id[k]));
            chk("rr_data", 32'(ifa.tx_Data),  32'(rr_data[k]));
            chk("rr_id",   32'(ifa.grant_Id), 32'(rr_id[k]));
            chk("rr_busy", 32'(ifa.busy),     32'd1);
            if (k > 0) chk("rr_gap", 32'(gap), 32'd11);
        end
        ifa.req = 4'd0;
        wait_idle(1'b0);

        // Single byte from requester 2
        ifa.req      = 4'b0100;
        ifa.req_Data = 32'h00A5_0000;
        #1;
        chk("sb_ack", 32'(ifa.req_Ack), 32'h4);
        step(1);
        chk("sb_start",     32'(ifa.tx_Start), 32'd1);
        chk("sb_data",      32'(ifa.tx_Data),  32'hA5);
        chk("sb_id",        32'(ifa.grant_Id), 32'd2);
        chk("sb_busy",      32'(ifa.busy),     32'd1);
        chk("sb_ack_clear", 32'(ifa.req_Ack),  32'd0);
        ifa.req      = 4'd0;
        ifa.req_Data = 32'h00FF_0000;
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (ifa.busy && !ifa.tx_Start) cnt++;
        end
        chk("sb_busy_len", 32'(cnt), 32'd9);
        step(1);
        chk("sb_busy_end", 32'(ifa.busy),     32'd0);
        chk("sb_data_hold", 32'(ifa.tx_Data), 32'hA5);
        chk("sb_id_hold",  32'(ifa.grant_Id), 32'd2);

        // Fairness after the pointer moves past requester 1
        ifa.req      = 4'b0010;
        ifa.req_Data = 32'h0000_5A00;
        wait_start(1'b0, gap, ack);
        chk("fair1_ack",  32'(ack),          32'h2);
        chk("fair1_id",   32'(ifa.grant_Id), 32'd1);
        chk("fair1_data", 32'(ifa.tx_Data),  32'h5A);
        ifa.req      = 4'b0011;
        ifa.req_Data = 32'h0000_1D0C;
        wait_start(1'b0, gap, ack);
        chk("fair2_ack",  32'(ack),          32'h1);
        chk("fair2_id",   32'(ifa.grant_Id), 32'd0);
        chk("fair2_data", 32'(ifa.tx_Data),  32'h0C);
        chk("fair2_gap",  32'(gap),          32'd11);
        ifa.req = 4'b0010;
        wait_start(1'b0, gap, ack);
        chk("fair3_ack",  32'(ack),          32'h2);
        chk("fair3_id",   32'(ifa.grant_Id), 32'd1);
        chk("fair3_data", 32'(ifa.tx_Data),  32'h1D);
        chk("fair3_gap",  32'(gap),          32'd11);
        ifa.req = 4'd0;
        wait_idle(1'b0);

        // Reset mid-frame; pointer would otherwise favour requester 1
        ifa.req      = 4'b0001;
        ifa.req_Data = 32'h0000_00C3;
        wait_start(1'b0, gap, ack);
        chk("mf_id", 32'(ifa.grant_Id), 32'd0);
        ifa.req = 4'd0;
        step(5);
        ifa.req      = 4'b0011;
        ifa.req_Data = 32'h0000_E7D4;
        #2;
        reset = 1'b0;
        #1;
        chk("mf_rst_start", 32'(ifa.tx_Start), 32'd0);
        chk("mf_rst_busy",  32'(ifa.busy),     32'd0);
        chk("mf_rst_data",  32'(ifa.tx_Data),  32'd0);
        chk("mf_rst_id",    32'(ifa.grant_Id), 32'd0);
        chk("mf_rst_ack",   32'(ifa.req_Ack),  32'd0);
        step(2);
        reset = 1'b1;
        wait_start(1'b0, gap, ack);
        chk("mf_post_ack",  32'(ack),          32'h1);
        chk("mf_post_id",   32'(ifa.grant_Id), 32'd0);
        chk("mf_post_data", 32'(ifa.tx_Data),  32'hD4);
        ifa.req = 4'd0;

        // Gap instance: tx_En dropped during the frame window with requester 3 pending
        ifb.tx_En    = 1'b1;
        ifb.req      = 4'b1000;
        ifb.req_Data = 32'h7700_0000;
        wait_start(1'b1, gap, ack);
        chk("gap1_ack",  32'(ack),          32'h8);
        chk("gap1_id",   32'(ifb.grant_Id), 32'd3);
        chk("gap1_data", 32'(ifb.tx_Data),  32'h77);
        ifb.req_Data = 32'h8800_0000;
        cnt    = 1;
        starts = 0;
        acks   = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (ifb.busy) cnt++;
        end
        ifb.tx_En = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step(1);
            if (ifb.busy) cnt++;
            if (ifb.tx_Start) starts++;
            if (ifb.req_Ack != 4'd0) acks++;
        end
        chk("gap_busy_len",  32'(cnt),    32'd14);
        chk("gap_no_start",  32'(starts), 32'd0);
        chk("gap_no_ack",    32'(acks),   32'd0);
        ifb.tx_En = 1'b1;
        #1;
        chk("gap_reen_ack", 32'(ifb.req_Ack), 32'h8);
        wait_start(1'b1, gap, ack);
        chk("gap_reen_gap",  32'(gap),         32'd1);
        chk("gap_reen_data", 32'(ifb.tx_Data), 32'h88);
        wait_start(1'b1, gap, ack);
        chk("gap_b2b_gap",  32'(gap),          32'd15);
        chk("gap_b2b_ack",  32'(ack),          32'h8);
        chk("gap_b2b_id",   32'(ifb.grant_Id), 32'd3);
        ifb.req   = 4'd0;
        ifb.tx_En = 1'b0;
        wait_idle(1'b1);

        chk("ack_invariant", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
